// File: rtl/cmpacc_pkg.sv
// Shared types and defaults for the compare-accelerator scheduler.
// Holds the FSM state encoding, width defaults and an id-width helper.
package cmpacc_pkg;

  localparam int BMP_W_DEF = 1536;
  localparam int RES_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cmpacc_sched_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after rr_ptr.
// Ports: req (requests), rr_ptr (last served), found, idx (winner).
module rr_arbiter_nreq #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  rr_ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  int j;

  // Scan rr_ptr+1 .. rr_ptr+NREQ; the last step wraps back to rr_ptr.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      j = (int'(rr_ptr) + i) % NREQ;
      if (!found && req[IDW'(j)]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/cmpacc_sched.sv
// Round-robin scheduler sharing one bitmap compare accelerator.
// Ports: req/req_bmp/gnt (clients), acc_* (accelerator), rsp_* (response), busy.
module cmpacc_sched
  import cmpacc_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int BMP_W   = BMP_W_DEF,
  parameter int RES_W   = RES_W_DEF,
  parameter int TIMEOUT = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*BMP_W-1:0]     req_bmp,
  output logic [NREQ-1:0]           gnt,
  output logic                      acc_wren,
  output logic [BMP_W-1:0]          acc_bitmap,
  input  logic                      acc_done,
  input  logic [RES_W-1:0]          acc_lshift,
  input  logic [RES_W-1:0]          acc_dshift,
  input  logic [RES_W-1:0]          acc_hscale,
  input  logic [RES_W-1:0]          acc_vscale,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      rsp_err,
  output logic [RES_W-1:0]          rsp_lshift,
  output logic [RES_W-1:0]          rsp_dshift,
  output logic [RES_W-1:0]          rsp_hscale,
  output logic [RES_W-1:0]          rsp_vscale,
  output logic                      busy
);

  localparam int IDW = id_w(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [IDW-1:0]   cur_id_q, cur_id_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [RES_W-1:0] lsh_q, lsh_d;
  logic [RES_W-1:0] dsh_q, dsh_d;
  logic [RES_W-1:0] hsc_q, hsc_d;
  logic [RES_W-1:0] vsc_q, vsc_d;

  logic             arb_found;
  logic [IDW-1:0]   arb_idx;

  rr_arbiter_nreq #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .found  (arb_found),
    .idx    (arb_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cur_id_q <= '0;
      rr_ptr_q <= IDW'(NREQ - 1);
      cnt_q    <= '0;
      err_q    <= 1'b0;
      lsh_q    <= '0;
      dsh_q    <= '0;
      hsc_q    <= '0;
      vsc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cur_id_q <= cur_id_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      lsh_q    <= lsh_d;
      dsh_q    <= dsh_d;
      hsc_q    <= hsc_d;
      vsc_q    <= vsc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_id_d = cur_id_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    lsh_d    = lsh_q;
    dsh_d    = dsh_q;
    hsc_d    = hsc_q;
    vsc_d    = vsc_q;
    unique case (state_q)
      IDLE: begin
        if (arb_found) begin
          cur_id_d = arb_idx;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Completion takes priority over the timeout edge.
        if (acc_done) begin
          lsh_d   = acc_lshift;
          dsh_d   = acc_dshift;
          hsc_d   = acc_hscale;
          vsc_d   = acc_vscale;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          lsh_d   = '0;
          dsh_d   = '0;
          hsc_d   = '0;
          vsc_d   = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rr_ptr_d = cur_id_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt        = '0;
    acc_wren   = 1'b0;
    acc_bitmap = '0;
    if (state_q == LOAD) begin
      gnt        = NREQ'(1) << cur_id_q;
      acc_wren   = 1'b1;
      acc_bitmap = req_bmp[cur_id_q*BMP_W +: BMP_W];
    end
  end

  assign rsp_valid  = (state_q == RESP);
  assign busy       = (state_q != IDLE);
  assign rsp_id     = cur_id_q;
  assign rsp_err    = err_q;
  assign rsp_lshift = lsh_q;
  assign rsp_dshift = dsh_q;
  assign rsp_hscale = hsc_q;
  assign rsp_vscale = vsc_q;

endmodule

// File: doc/cmpacc_sched.md
Name: cmpacc_sched

Overview:
Round-robin scheduler that shares one compare accelerator (bitmap compare unit producing lshift/dshift/hscale/vscale) between NREQ requesters.
- Per job: picks a requester, loads its 1536-bit bitmap into the accelerator with a one-cycle write pulse, waits for done or timeout, then captures the four 16-bit results.
- Returns the results to the requester through a valid/ready response channel.
- Sits between the note-recognition clients and the accelerator top.

Parameters:
NREQ, 4, number of requesters (2..8)
BMP_W, 1536, bitmap width in bits
RES_W, 16, width of each result
TIMEOUT, 1023, max WAIT cycles before abort (must be >= 1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
req  input  NREQ  per-requester job request, level; held until gnt
req_bmp  input  NREQ*BMP_W  bitmaps, requester i at bits [i*BMP_W +: BMP_W]; stable while req[i]=1
gnt  output  NREQ  one-hot, one-cycle acceptance pulse
acc_wren  output  1  bitmap write strobe to accelerator
acc_bitmap  output  BMP_W  bitmap to accelerator
acc_done  input  1  accelerator completion, one-cycle pulse
acc_lshift  input  RES_W  accelerator result
acc_dshift  input  RES_W  accelerator result
acc_hscale  input  RES_W  accelerator result
acc_vscale  input  RES_W  accelerator result
rsp_valid  output  1  response valid
rsp_ready  input  1  response accepted
rsp_id  output  $clog2(NREQ)  requester index of response
rsp_err  output  1  1 = job timed out; results are zero
rsp_lshift  output  RES_W  captured result
rsp_dshift  output  RES_W  captured result
rsp_hscale  output  RES_W  captured result
rsp_vscale  output  RES_W  captured result
busy  output  1  state != IDLE

Behaviour:
- Reset (async, immediate):
  - state=IDLE; all outputs 0.
  - rr_ptr=NREQ-1, so requester 0 has first priority.
  - Timeout counter 0; result registers 0.
  - Reset mid-job abandons the job with no response; the accelerator is not notified.
- States: IDLE, LOAD, WAIT, RESP.
- IDLE:
  - If any req bit is set, select the first set bit scanning rr_ptr+1, rr_ptr+2, ... modulo NREQ; latch it as cur_id; go to LOAD.
  - No req: stay.
- LOAD (exactly 1 cycle):
  - gnt[cur_id]=1, acc_wren=1, acc_bitmap=req_bmp slice cur_id.
  - Clear the timeout counter; go to WAIT.
  - acc_bitmap is 0 in all other states.
- WAIT, each cycle:
  - acc_done=1: register the four acc_* results, rsp_err=0, go to RESP.
  - Else if counter==TIMEOUT-1: zero the results, rsp_err=1, go to RESP.
  - Else increment the counter.
  - Done and the timeout edge in the same cycle: done wins.
- acc_done outside WAIT is ignored.
- RESP:
  - rsp_valid=1; rsp_id, rsp_err and rsp_* stay stable while valid.
  - When rsp_valid && rsp_ready: rr_ptr=cur_id, go to IDLE, valid drops the next cycle.
- Latency, done-to-valid: 1 cycle.
- Minimum job length: 4 cycles (IDLE, LOAD, 1 WAIT, RESP with ready held high).
- Back-to-back: a new grant can occur at the earliest 1 cycle after the handshake (IDLE cycle).
- A requester dropping req before gnt: allowed; it is simply not selected.
- req bits change during LOAD/WAIT/RESP: no effect on the current job.
- Timeout counter width: $clog2(TIMEOUT+1); it never wraps.

Decomposition:
- Shared package cmpacc_pkg holds:
  - state enum (IDLE=0, LOAD=1, WAIT=2, RESP=3)
  - BMP_W and RES_W defaults
  - function for the id width
- One natural sub-module, rr_arbiter_nreq: combinational round-robin pick from req and rr_ptr, returning a found flag and an index. Everything else stays in cmpacc_sched.

Test Plan:
- Single job: req=4'b0001, acc_done 5 cycles after acc_wren with lshift=0x0003, dshift=0xFFFE, hscale=0x0100, vscale=0x0080 -> gnt[0] and acc_wren pulse together; rsp_valid 1 cycle after done with rsp_id=0, rsp_err=0 and those values.
- Fairness: req=4'b1111 held, rsp_ready=1, done 2 cycles after each load -> grants in order 0,1,2,3,0; no requester is granted twice before the others.
- Backpressure: rsp_ready=0 for 10 cycles after valid -> valid and all rsp_* stable for 10 cycles; no new gnt or acc_wren; clears the cycle after ready=1.
- Timeout: TIMEOUT=8, acc_done never asserted -> RESP entered after 8 WAIT cycles with rsp_err=1 and all results 0x0000; a stray done in RESP is ignored.
- Edge cases: done on the final timeout cycle -> rsp_err=0, results captured. rst asserted in WAIT -> outputs 0 immediately; the next job with req=4'b1000|4'b0001 grants requester 0.
